// File: rtl/mux2_arb_ctrl.sv
// mux2_arb_ctrl: two-source round-robin arbiter driving a 2:1 mux select and a registered merged stream.
// Defining MUX2_ARB_FAIRNESS_EN enables the HOLD_MAX-beat grant limit with direct grant hand-over.
module mux2_arb_ctrl #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(HOLD_MAX + 1);

`ifdef MUX2_ARB_FAIRNESS_EN
    localparam logic FAIR_EN = 1'b1;
`else
    localparam logic FAIR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept_s;
    logic             own_valid_s;
    logic             oth_valid_s;
    logic [WIDTH-1:0] own_data_s;
    logic             xfer_s;
    logic [CW-1:0]    cnt_inc_s;

    assign accept_s  = out_ready | ~out_valid_q;
    assign in1_ready = (state_q == GRANT1) & accept_s;
    assign in2_ready = (state_q == GRANT2) & accept_s;
    assign xfer_s    = own_valid_s & accept_s;
    assign cnt_inc_s = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + CW'(1);

    // Route the current owner's (and the other source's) handshake signals.
    always_comb begin
        own_valid_s = 1'b0;
        oth_valid_s = 1'b0;
        own_data_s  = {WIDTH{1'b0}};
        case (state_q)
            GRANT1: begin
                own_valid_s = in1_valid;
                oth_valid_s = in2_valid;
                own_data_s  = in1;
            end
            GRANT2: begin
                own_valid_s = in2_valid;
                oth_valid_s = in1_valid;
                own_data_s  = in2;
            end
            default: begin
                own_valid_s = 1'b0;
                oth_valid_s = 1'b0;
                own_data_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    // Grant FSM next state plus output-register and bookkeeping updates.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        if (xfer_s) begin
            out_d       = own_data_s;
            out_valid_d = 1'b1;
            cnt_d       = cnt_inc_s;
            last_d      = (state_q == GRANT2) ? 2'd2 : 2'd1;
        end else if (accept_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                // On a tie the source that was not served last wins.
                if (in1_valid & (~in2_valid | (last_q != 2'd1))) begin
                    state_d = GRANT1;
                    s_d     = 1'b0;
                    cnt_d   = {CW{1'b0}};
                end else if (in2_valid) begin
                    state_d = GRANT2;
                    s_d     = 1'b1;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT1, GRANT2: begin
                if (FAIR_EN & xfer_s & (cnt_inc_s == CW'(HOLD_MAX)) & oth_valid_s) begin
                    state_d = (state_q == GRANT1) ? GRANT2 : GRANT1;
                    s_d     = ~s_q;
                    cnt_d   = {CW{1'b0}};
                end else if (!own_valid_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            last_q      <= 2'd2;
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign s         = s_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2_arb_ctrl.sv
// Randomized self-checking bench for mux2_arb_ctrl against a transaction-level arbitration model.
module tb_mux2_arb_ctrl;

    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic             in1_valid = 1'b0;
    logic             in1_ready;
    logic [WIDTH-1:0] in2 = '0;
    logic             in2_valid = 1'b0;
    logic             in2_ready;
    logic             s;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready = 1'b0;

    mux2_arb_ctrl #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in2       (in2),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .s         (s),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

`ifdef MUX2_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner 0 = nobody, 1/2 = source; the output slot is a queue of pending beats.
    int               m_owner;
    int               m_last;
    int               m_run;
    bit               m_s;
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] m_slot[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_run   = 0;
        m_s     = 1'b0;
        m_out   = '0;
        m_slot.delete();
    endtask

    task automatic model_step(input bit v1, input logic [WIDTH-1:0] d1,
                              input bit v2, input logic [WIDTH-1:0] d2, input bit ordy);
        bit               acc;
        bit               ov;
        bit               oth;
        int               nxt;
        logic [WIDTH-1:0] od;
        acc = ordy || (m_slot.size() == 0);
        if (m_slot.size() != 0 && ordy) void'(m_slot.pop_front());
        if (m_owner == 0) begin
            if (v1 && v2)  nxt = (m_last == 1) ? 2 : 1;
            else if (v1)   nxt = 1;
            else if (v2)   nxt = 2;
            else           nxt = 0;
            if (nxt != 0) begin
                m_owner = nxt;
                m_s     = (nxt == 2);
                m_run   = 0;
            end
        end else begin
            ov  = (m_owner == 1) ? v1 : v2;
            oth = (m_owner == 1) ? v2 : v1;
            od  = (m_owner == 1) ? d1 : d2;
            if (ov && acc) begin
                m_slot.push_back(od);
                m_out  = od;
                m_last = m_owner;
                if (m_run < HOLD_MAX) m_run++;
                if (FAIR && m_run == HOLD_MAX && oth) begin
                    m_owner = 3 - m_owner;
                    m_s     = ~m_s;
                    m_run   = 0;
                end
            end else if (!ov) begin
                m_owner = 0;
            end
        end
    endtask

    task automatic cycle(input bit v1, input logic [WIDTH-1:0] d1,
                         input bit v2, input logic [WIDTH-1:0] d2, input bit ordy);
        bit acc;
        @(negedge clk);
        in1_valid = v1;
        in1       = d1;
        in2_valid = v2;
        in2       = d2;
        out_ready = ordy;
        #1;
        acc = ordy || (m_slot.size() == 0);
        check_eq("s", 32'(s), 32'(m_s));
        check_eq("out_valid", 32'(out_valid), 32'(m_slot.size() != 0));
        check_eq("out", 32'(out), 32'(m_out));
        check_eq("in1_ready", 32'(in1_ready), 32'(m_owner == 1 && acc));
        check_eq("in2_ready", 32'(in2_ready), 32'(m_owner == 2 && acc));
        model_step(v1, d1, v2, d2, ordy);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_s"}, 32'(s), 32'd0);
        check_eq({tag, "_out"}, 32'(out), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in1_ready"}, 32'(in1_ready), 32'd0);
        check_eq({tag, "_in2_ready"}, 32'(in2_ready), 32'd0);
    endtask

    initial begin
        model_reset();
        // Valids high during reset must not produce readies.
        in1_valid = 1'b1;
        in2_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("rst");
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset, then in1 drops and in2 gets its turn.
        repeat (3) cycle(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 8'hB2, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Single source stream.
        cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Backpressure: out held for three cycles, then drains with no loss.
        cycle(1'b1, 8'h40, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h41, 1'b0, 8'h00, 1'b1);
        repeat (3) cycle(1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h43, 1'b0, 8'h00, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Both sources continuously valid: hold-limit switching or a sticky grant.
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, 8'(8'h90 + i), 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a cycle with a beat pending.
        repeat (3) cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
        check_eq("pre_rst_out_valid", 32'(out_valid), 32'(m_slot.size() != 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 8, WIDTH'($urandom),
                  $urandom_range(0, 9) < 7, WIDTH'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
